exec_pipe_unit: RTL
===================

# exec_pipe_unit

Parametrised, registered execute stage for the WISC pipeline. Takes decoded operands from the ID/EX boundary, computes ALU, set-condition and branch/jump results, and holds them in its own EX/MEM output register under a valid/ready handshake. Supersedes the fixed 16-bit combinational execute path with a configurable data width, stall support and an optional multi-cycle multiplier.

## Interface
- WIDTH, 16: datapath width; power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  operation presented
- id_ready  out  1  stage accepts this cycle
- id_alu_op  in  4  operation code (package enum)
- id_br_type  in  3  NOBR/EQZ/NEZ/LTZ/GEQZ
- id_jump, id_return  in  1 each  unconditional jump; target base is reg1 rather than pc_incr
- id_use_imm  in  1  B operand = id_imm, else id_reg2
- id_pc_incr, id_reg1, id_reg2, id_imm, id_offset  in  WIDTH each  PC+2, operands, pre-extended immediate and branch offset
- id_wb_reg  in  3  destination register, passed through
- ex_valid  out  1  output register holds a result
- mem_ready  in  1  downstream accepts the result
- ex_result, ex_store_data  out  WIDTH each  ALU/set result; registered reg2
- ex_wb_reg  out  3  registered destination
- redirect  out  1  taken branch or jump, one-cycle qualified by ex_valid
- redirect_pc  out  WIDTH  target address
- err  out  1  sticky illegal op/br_type flag

## Operation
- A = id_reg1; B = id_use_imm ? id_imm : id_reg2.
- Ops: ADD, SUB (B-A), AND, OR, XOR, ANDN, SLL, SRL, SRA, ROL (amount = B[SHW-1:0]), SEQ, SLT, SLE, SCO, BTR (bit reverse of A), MUL (only with EXEC_MUL_EN).
- Set ops yield 0 or 1: SLT = signed A<B from sign^overflow of A-B; SLE = SLT|equal; SCO = carry-out of A+B.
- Arithmetic wraps modulo 2^WIDTH; MUL returns low WIDTH bits of the unsigned product.
- Branch compares reg1 with zero: EQZ = zero, NEZ = !zero, LTZ = reg1[WIDTH-1], GEQZ = !reg1[WIDTH-1].
- Target = (id_return ? id_reg1 : id_pc_incr) + id_offset, modulo 2^WIDTH.
- redirect = taken branch or id_jump, registered together with the result.
- An illegal op or br_type (codes 5-7) sets err, completes as a NOP with ex_result=0 and redirect=0, and err stays set until reset.
- FSM states: IDLE, MUL, HOLD.
  - IDLE --accept MUL--> MUL.
  - MUL runs WIDTH shift-add iterations, then goes to HOLD.
  - HOLD --mem_ready--> IDLE.
  - Single-cycle ops stay in IDLE.

## Timing
- Accept when id_valid && id_ready. id_ready = !rst && state==IDLE && (!ex_valid || mem_ready).
- Single-cycle op: result and redirect appear in ex_* on the cycle after accept (latency 1). Back-to-back accepts give full throughput while mem_ready=1.
- MUL: id_ready=0 for WIDTH cycles; ex_valid rises WIDTH+1 cycles after accept.
- When ex_valid && !mem_ready, every ex_* output and redirect holds stable and no operation is accepted.
- A handoff (ex_valid && mem_ready) with no new accept clears ex_valid and redirect on the next edge.
- Reset value of every output is 0, except id_ready, which returns to 1 on the first cycle after reset. Reset mid-MUL abandons the multiply and discards its result; state goes to IDLE.
- Upstream flushes the younger instruction on redirect; this stage never flushes its own register.

## Configuration
- EXEC_MUL_EN defined: MUL state, the iterative multiplier and its WIDTH+1 latency are present.
- Not defined: the MUL opcode is illegal (sets err, NOP, latency 1), and the FSM reduces to IDLE/HOLD behaviour.

## Structure
- Package exec_pkg holds the alu_op_e enum, br_type_e enum (NOBR=0, EQZ=1, NEZ=2, LTZ=3, GEQZ=4) and the state_e enum.
- Sub-module exec_iter_mul(WIDTH) implements the shift-add multiplier with start/done handshake. The ALU, branch logic and output register stay in the top module.

## Test plan
- WIDTH=16, ADD A=0x7FFF B=0x0001 → ex_result=0x8000 one cycle after accept; SLT 0x8000,0x0001 → 1.
- BR_EQZ reg1=0, pc_incr=0x0010, offset=0xFFFC → redirect=1, redirect_pc=0x000C; NEZ with same inputs → redirect=0.
- id_return=1, reg1=0x1234, offset=0x0002, id_jump=1 → redirect_pc=0x1236.
- mem_ready held 0 for 3 cycles after a result → ex_* stable, id_ready=0; mem_ready=1 → next op accepted the same cycle.
- EXEC_MUL_EN, MUL 0x0003×0x0005 → ex_result=0x000F at accept+17; rst asserted at accept+5 → ex_valid=0, id_ready=1 after reset.
- br_type=7 → err=1 and stays 1 across later legal ops until rst; ex_result=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the WISC execute stage: ALU opcodes, branch types and FSM states.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_ANDN = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_ROL  = 4'd9,
        OP_SEQ  = 4'd10,
        OP_SLT  = 4'd11,
        OP_SLE  = 4'd12,
        OP_SCO  = 4'd13,
        OP_BTR  = 4'd14,
        OP_MUL  = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NOBR = 3'd0,
        BR_EQZ  = 3'd1,
        BR_NEZ  = 3'd2,
        BR_LTZ  = 3'd3,
        BR_GEQZ = 3'd4
    } br_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [2:0] BR_LAST_LEGAL = 3'd4;

endpackage

// File: rtl/exec_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
module exec_iter_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_step;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    // done and product are valid during the final iteration so the caller can capture on that edge
    assign done_o   = busy_q && (cnt_q == CW'(1));
    assign prod_o   = acc_step;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            cnt_d    = CW'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            busy_d   = (cnt_q != CW'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/exec_pipe_unit.sv
// Registered WISC execute stage: ALU, set-condition, branch/jump resolution and EX/MEM register.
// Optional iterative multiplier enabled by defining EXEC_MUL_EN.
module exec_pipe_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [3:0]       id_alu_op,
    input  logic [2:0]       id_br_type,
    input  logic             id_jump,
    input  logic             id_return,
    input  logic             id_use_imm,
    input  logic [WIDTH-1:0] id_pc_incr,
    input  logic [WIDTH-1:0] id_reg1,
    input  logic [WIDTH-1:0] id_reg2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [WIDTH-1:0] id_offset,
    input  logic [2:0]       id_wb_reg,
    output logic             ex_valid,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] ex_result,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [2:0]       ex_wb_reg,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q;
    logic             ex_valid_q, redirect_q, redir_pend_q, err_q;
    logic [WIDTH-1:0] ex_result_q, ex_store_data_q, redirect_pc_q;
    logic [2:0]       ex_wb_reg_q;

    alu_op_e          op;
    logic [WIDTH-1:0] opa, opb, diff, alu_res, target, rol_res, btr_res;
    logic [WIDTH:0]   sum_c;
    logic [SHW-1:0]   amt;
    logic [SHW:0]     ramt;
    logic             ovf, slt, eq, taken, op_illegal, br_illegal, illegal;
    logic             accept, is_mul, redir_now, mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign op     = alu_op_e'(id_alu_op);
    assign opa    = id_reg1;
    assign opb    = id_use_imm ? id_imm : id_reg2;
    assign amt    = opb[SHW-1:0];
    assign ramt   = (SHW+1)'(WIDTH) - {1'b0, amt};
    assign sum_c  = {1'b0, opa} + {1'b0, opb};
    assign diff   = opa - opb;
    assign ovf    = (opa[WIDTH-1] ^ opb[WIDTH-1]) & (diff[WIDTH-1] ^ opa[WIDTH-1]);
    assign slt    = diff[WIDTH-1] ^ ovf;
    assign eq     = (opa == opb);
    // shifting by WIDTH yields zero, so amt==0 rotates to A unchanged
    assign rol_res = (opa << amt) | (opa >> ramt);

    always_comb begin
        btr_res = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            btr_res[i] = opa[WIDTH-1-i];
        end
    end

`ifdef EXEC_MUL_EN
    assign op_illegal = 1'b0;
`else
    assign op_illegal = (op == OP_MUL);
`endif
    assign br_illegal = (id_br_type > BR_LAST_LEGAL);
    assign illegal    = op_illegal | br_illegal;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = sum_c[WIDTH-1:0];
            OP_SUB:  alu_res = opb - opa;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_ANDN: alu_res = opa & ~opb;
            OP_SLL:  alu_res = opa << amt;
            OP_SRL:  alu_res = opa >> amt;
            OP_SRA:  alu_res = $signed(opa) >>> amt;
            OP_ROL:  alu_res = rol_res;
            OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, eq};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLE:  alu_res = {{(WIDTH-1){1'b0}}, slt | eq};
            OP_SCO:  alu_res = {{(WIDTH-1){1'b0}}, sum_c[WIDTH]};
            OP_BTR:  alu_res = btr_res;
            default: alu_res = '0;
        endcase
        if (illegal) alu_res = '0;
    end

    always_comb begin
        taken = 1'b0;
        case (id_br_type)
            BR_EQZ:  taken = (id_reg1 == '0);
            BR_NEZ:  taken = (id_reg1 != '0);
            BR_LTZ:  taken = id_reg1[WIDTH-1];
            BR_GEQZ: taken = !id_reg1[WIDTH-1];
            default: taken = 1'b0;
        endcase
    end

    assign target    = (id_return ? id_reg1 : id_pc_incr) + id_offset;
    assign redir_now = !illegal && (taken || id_jump);
    assign id_ready  = !rst && (state_q == IDLE) && (!ex_valid_q || mem_ready);
    assign accept    = id_valid && id_ready;
    assign is_mul    = !illegal && (op == OP_MUL);

`ifdef EXEC_MUL_EN
    exec_iter_mul #(.WIDTH(WIDTH)) u_mul (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (accept && is_mul),
        .a_i     (opa),
        .b_i     (opb),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            ex_valid_q      <= 1'b0;
            redirect_q      <= 1'b0;
            redir_pend_q    <= 1'b0;
            err_q           <= 1'b0;
            ex_result_q     <= '0;
            ex_store_data_q <= '0;
            redirect_pc_q   <= '0;
            ex_wb_reg_q     <= '0;
        end else begin
            if (accept && illegal) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ex_wb_reg_q     <= id_wb_reg;
                        ex_store_data_q <= id_reg2;
                        redirect_pc_q   <= target;
                        if (is_mul) begin
                            // sideband loads now while ex_valid is low; redirect waits for the product
                            state_q      <= MUL;
                            ex_valid_q   <= 1'b0;
                            redirect_q   <= 1'b0;
                            redir_pend_q <= redir_now;
                        end else begin
                            ex_valid_q  <= 1'b1;
                            ex_result_q <= alu_res;
                            redirect_q  <= redir_now;
                        end
                    end else if (ex_valid_q && mem_ready) begin
                        ex_valid_q <= 1'b0;
                        redirect_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        ex_result_q <= mul_prod;
                        ex_valid_q  <= 1'b1;
                        redirect_q  <= redir_pend_q;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (mem_ready) begin
                        ex_valid_q <= 1'b0;
                        redirect_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_result     = ex_result_q;
    assign ex_store_data = ex_store_data_q;
    assign ex_wb_reg     = ex_wb_reg_q;
    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign err           = err_q;

endmodule
